// File: rtl/sync_counter_pkg.sv
// Shared constants for the down-counter family: default width and FSM state encoding.
package sync_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage : sync_counter_pkg

// File: rtl/sync_down_counter_if.sv
// Bundles the control and status signals of sync_down_counter for benches and parent blocks.
interface sync_down_counter_if
    import sync_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic clk
);
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             auto_reload;
    logic [WIDTH-1:0] Q;
    logic             tc;
    logic             busy;
    logic             done;

    // master drives the controls and observes status; slave is the counter side
    modport master (
        input  clk,
        output enable, load, load_val, auto_reload,
        input  Q, tc, busy, done
    );

    modport slave (
        input  clk,
        input  enable, load, load_val, auto_reload,
        output Q, tc, busy, done
    );

endinterface : sync_down_counter_if

// File: rtl/sync_down_counter.sv
// Loadable down counter with one-shot / periodic modes and a registered terminal-count pulse.
module sync_down_counter
    import sync_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q,     tc_d;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (load) begin
            // Load wins in every state, including a coincident terminal cycle, so tc stays low.
            reload_d = load_val;
            count_d  = load_val;
            state_d  = (load_val != ZERO) ? ST_RUN : ST_IDLE;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (enable) begin
                        if (count_q > ONE) begin
                            count_d = count_q - ONE;
                        end else if (auto_reload) begin
                            count_d = reload_q;
                            tc_d    = 1'b1;
                        end else begin
                            count_d = ZERO;
                            state_d = ST_DONE;
                            tc_d    = 1'b1;
                        end
                    end
                end
                ST_IDLE, ST_DONE: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = ZERO;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= ZERO;
            reload_q <= ZERO;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign Q    = count_q;
    assign tc   = tc_q;
    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

endmodule : sync_down_counter

// File: tb/tb_sync_down_counter.sv
// Directed self-checking bench for sync_down_counter with hand-computed expected sequences.
module tb_sync_down_counter;

    localparam int WIDTH = 4;

    logic clk;
    logic reset;

    sync_down_counter_if #(.WIDTH(WIDTH)) dut_if (.clk(clk));

    sync_down_counter #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (dut_if.enable),
        .load        (dut_if.load),
        .load_val    (dut_if.load_val),
        .auto_reload (dut_if.auto_reload),
        .Q           (dut_if.Q),
        .tc          (dut_if.tc),
        .busy        (dut_if.busy),
        .done        (dut_if.done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] val, input logic ar);
        dut_if.load        = 1'b1;
        dut_if.load_val    = val;
        dut_if.auto_reload = ar;
        dut_if.enable      = 1'b1;
        step();
        dut_if.load = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_q [$];
        logic       exp_tc [$];

        reset              = 1'b1;
        dut_if.enable      = 1'b0;
        dut_if.load        = 1'b0;
        dut_if.load_val    = '0;
        dut_if.auto_reload = 1'b0;

        #3;
        check("reset_q", dut_if.Q, 0);
        check("reset_tc", dut_if.tc, 0);
        check("reset_busy", dut_if.busy, 0);
        check("reset_done", dut_if.done, 0);
        #4 reset = 1'b0;

        // One-shot: load 5, first posedge after reset release
        do_load(4'd5, 1'b0);
        check("os_load_q", dut_if.Q, 5);
        check("os_load_busy", dut_if.busy, 1);
        check("os_load_tc", dut_if.tc, 0);
        exp_q  = '{4, 3, 2, 1, 0};
        exp_tc = '{0, 0, 0, 0, 1};
        foreach (exp_q[i]) begin
            step();
            check($sformatf("os_q[%0d]", i), dut_if.Q, exp_q[i]);
            check($sformatf("os_tc[%0d]", i), dut_if.tc, exp_tc[i]);
        end
        check("os_done", dut_if.done, 1);
        check("os_busy_end", dut_if.busy, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("os_hold_q[%0d]", i), dut_if.Q, 0);
            check($sformatf("os_hold_tc[%0d]", i), dut_if.tc, 0);
            check($sformatf("os_hold_done[%0d]", i), dut_if.done, 1);
        end

        // Periodic: load 3 with auto_reload
        do_load(4'd3, 1'b1);
        check("per_load_q", dut_if.Q, 3);
        exp_q  = '{2, 1, 3, 2, 1, 3, 2};
        exp_tc = '{0, 0, 1, 0, 0, 1, 0};
        foreach (exp_q[i]) begin
            step();
            check($sformatf("per_q[%0d]", i), dut_if.Q, exp_q[i]);
            check($sformatf("per_tc[%0d]", i), dut_if.tc, exp_tc[i]);
            check($sformatf("per_busy[%0d]", i), dut_if.busy, 1);
        end

        // Hold: load 9, pause two cycles at Q = 4
        do_load(4'd9, 1'b0);
        check("hold_load_q", dut_if.Q, 9);
        exp_q = '{8, 7, 6, 5, 4};
        foreach (exp_q[i]) begin
            step();
            check($sformatf("hold_run_q[%0d]", i), dut_if.Q, exp_q[i]);
        end
        dut_if.enable = 1'b0;
        step();
        check("hold_q0", dut_if.Q, 4);
        step();
        check("hold_q1", dut_if.Q, 4);
        check("hold_busy", dut_if.busy, 1);
        dut_if.enable = 1'b1;
        step();
        check("hold_resume_q", dut_if.Q, 3);

        // Reset mid-count: asynchronous, between edges
        do_load(4'd9, 1'b0);
        for (int i = 0; i < 3; i++) step();
        check("rst_pre_q", dut_if.Q, 6);
        reset = 1'b1;
        #1;
        check("rst_mid_q", dut_if.Q, 0);
        check("rst_mid_busy", dut_if.busy, 0);
        check("rst_mid_tc", dut_if.tc, 0);
        #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("rst_after_tc[%0d]", i), dut_if.tc, 0);
            check($sformatf("rst_after_q[%0d]", i), dut_if.Q, 0);
        end

        // Full range: load 15 counts 15 steps to 0
        do_load(4'hF, 1'b0);
        check("max_load_q", dut_if.Q, 15);
        for (int i = 1; i <= 15; i++) begin
            step();
            check($sformatf("max_q[%0d]", i), dut_if.Q, 15 - i);
            check($sformatf("max_tc[%0d]", i), dut_if.tc, (i == 15) ? 1 : 0);
        end
        check("max_done", dut_if.done, 1);

        // Load 0 goes to IDLE without tc
        do_load(4'd5, 1'b0);
        do_load(4'd0, 1'b0);
        check("zero_q", dut_if.Q, 0);
        check("zero_busy", dut_if.busy, 0);
        check("zero_done", dut_if.done, 0);
        check("zero_tc", dut_if.tc, 0);
        step();
        check("zero_tc_next", dut_if.tc, 0);
        check("zero_q_next", dut_if.Q, 0);

        // Load in the terminal cycle wins and suppresses tc
        do_load(4'd2, 1'b0);
        step();
        check("term_pre_q", dut_if.Q, 1);
        do_load(4'd7, 1'b0);
        check("term_load_q", dut_if.Q, 7);
        check("term_load_tc", dut_if.tc, 0);
        check("term_load_busy", dut_if.busy, 1);

        // Reload value 1 in periodic mode keeps tc high continuously
        do_load(4'd1, 1'b1);
        check("r1_load_tc", dut_if.tc, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("r1_q[%0d]", i), dut_if.Q, 1);
            check($sformatf("r1_tc[%0d]", i), dut_if.tc, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sync_down_counter
